// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle around the FFT frame sequencer: config channel,
// sample input, core input, core output monitor taps and core event.
//
// master : sequencer side (drives cfg_*, s_tready, fft_tdata/tvalid/tlast)
// slave  : environment side (reader, FFT core and its output monitor)
interface fft_frame_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [23:0]       cfg_tdata;
    logic              cfg_tvalid;
    logic              cfg_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic [DATA_W-1:0] fft_tdata;
    logic              fft_tvalid;
    logic              fft_tlast;
    logic              fft_tready;
    logic              mon_tvalid;
    logic              mon_tready;
    logic              mon_tlast;
    logic              ev_tlast_err;

    modport master (
        output cfg_tdata, cfg_tvalid, s_tready,
        output fft_tdata, fft_tvalid, fft_tlast,
        input  cfg_tready, s_tdata, s_tvalid, s_tlast,
        input  fft_tready, mon_tvalid, mon_tready, mon_tlast,
        input  ev_tlast_err
    );

    modport slave (
        input  cfg_tdata, cfg_tvalid, s_tready,
        input  fft_tdata, fft_tvalid, fft_tlast,
        output cfg_tready, s_tdata, s_tvalid, s_tlast,
        output fft_tready, mon_tvalid, mon_tready, mon_tlast,
        output ev_tlast_err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Sequences one capture through a streaming FFT core: one config word,
// then NFRAMES windows of NFFT samples with locally generated tlast.
//
// Ports: clk, arstn (async, active low), start (capture request),
// busy/done/err/err_code status, bus (stream bundle, master side),
// frames_in / frames_out (frames entering / leaving the core).
module fft_frame_sequencer #(
    parameter int          NFFT        = 512,
    parameter int          NFRAMES     = 100,
    parameter int          DATA_W      = 32,
    parameter logic [17:0] SCALE_SCHED = 18'hAAA,
    parameter logic        FWD         = 1'b1,
    parameter int          TIMEOUT     = 4096
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     err_code,
    fft_frame_sequencer_if.master          bus,
    output logic [$clog2(NFRAMES+1)-1:0]   frames_in,
    output logic [$clog2(NFRAMES+1)-1:0]   frames_out
);
    localparam int FW = $clog2(NFRAMES + 1);
    localparam int CW = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NFFT - 1);
    localparam logic [FW-1:0] FR_MAX   = FW'(NFRAMES);
    localparam logic [FW-1:0] FR_LAST  = FW'(NFRAMES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [23:0]   CFG_WORD = {5'b0, SCALE_SCHED, FWD};

    typedef enum logic [1:0] {
        IDLE, CONFIG, STREAM, DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [WW-1:0]     wd;
    logic [DATA_W-1:0] pass_data;
    logic              gate;
    logic              active;
    logic              start_ok;
    logic              cfg_hs;
    logic              fft_hs;
    logic              mon_hs;
    logic              mon_last_hs;
    logic              last_frame;
    logic              abort;
    logic [1:0]        abort_code;

    assign active      = (state == STREAM) || (state == DRAIN);
    assign start_ok    = (state == IDLE) && start;
    assign cfg_hs      = bus.cfg_tvalid && bus.cfg_tready;
    assign fft_hs      = bus.fft_tvalid && bus.fft_tready;
    assign mon_hs      = active && bus.mon_tvalid && bus.mon_tready;
    assign mon_last_hs = mon_hs && bus.mon_tlast;
    assign last_frame  = fft_hs && bus.fft_tlast && (frames_in == FR_LAST);
    assign abort       = abort_code != 2'd0;

    // Zero-latency gated pass-through; nothing is buffered.
    assign pass_data      = bus.s_tdata;
    assign bus.fft_tdata  = pass_data;
    assign bus.fft_tvalid = bus.s_tvalid && gate;
    assign bus.s_tready   = bus.fft_tready && gate;
    assign bus.fft_tlast  = gate && (cnt == CNT_LAST);
    assign bus.cfg_tdata  = CFG_WORD;

    // Several error sources may fire together: the lowest code wins.
    always_comb begin
        abort_code = 2'd0;
        if (fft_hs && (bus.s_tlast != bus.fft_tlast))
            abort_code = 2'd1;
        else if (active && bus.ev_tlast_err)
            abort_code = 2'd2;
        else if (active && !fft_hs && !mon_hs && (wd == WD_LAST))
            abort_code = 2'd3;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CONFIG;
            CONFIG: if (cfg_hs) state_nxt = STREAM;
            STREAM: begin
                if (abort)           state_nxt = IDLE;
                else if (last_frame) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)                     state_nxt = IDLE;
                else if (frames_out == FR_MAX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        bus.cfg_tvalid = 1'b0;
        gate           = 1'b0;
        unique case (1'b1)
            (state == CONFIG): begin
                busy           = 1'b1;
                bus.cfg_tvalid = 1'b1;
            end
            (state == STREAM): begin
                busy = 1'b1;
                gate = 1'b1;
            end
            (state == DRAIN): busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt        <= '0;
            wd         <= '0;
            frames_in  <= '0;
            frames_out <= '0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            done       <= 1'b0;
        end else begin
            done <= (state == DRAIN) && !abort && (frames_out == FR_MAX);
            if (start_ok) begin
                cnt        <= '0;
                wd         <= '0;
                frames_in  <= '0;
                frames_out <= '0;
                err        <= 1'b0;
                err_code   <= 2'd0;
            end else begin
                if (fft_hs)
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (fft_hs && bus.fft_tlast && (frames_in != FR_MAX))
                    frames_in <= frames_in + 1'b1;
                if (mon_last_hs && (frames_out != FR_MAX))
                    frames_out <= frames_out + 1'b1;
                // Watchdog: any handshake on either side counts as progress.
                if (active)
                    wd <= (fft_hs || mon_hs) ? '0 : wd + 1'b1;
                if (active && abort) begin
                    err      <= 1'b1;
                    err_code <= abort_code;
                end
            end
        end
    end
endmodule
